// File: rtl/tic_tac_toe_game_ctrl.sv
// Tic-tac-toe game controller: owns the board, alternates turns,
// validates moves and declares win, draw or timeout forfeit.
module tic_tac_toe_game_ctrl #(
  parameter logic        FIRST_PLAYER = 1'b0,
  parameter int unsigned TURN_TIMEOUT = 0,
  parameter int unsigned TIMER_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        move_valid,
  input  logic [3:0]  move_cell,
  output logic        move_ready,
  output logic        move_accept,
  output logic        move_reject,
  output logic        current_player,
  output logic [26:0] board,
  output logic [3:0]  move_count,
  output logic [1:0]  game_state,
  output logic [1:0]  winner,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_MOVE = 2'b01,
    CHECK     = 2'b10,
    DONE      = 2'b11
  } state_e;

  localparam logic [2:0] SYM_O = 3'b000;
  localparam logic [2:0] SYM_X = 3'b001;
  localparam logic [2:0] EMPTY = 3'b011;
  localparam logic [26:0] BOARD_CLR = {9{EMPTY}};

  localparam logic [TIMER_W-1:0] TMAX =
    (TURN_TIMEOUT == 0) ? '0 : TIMER_W'(TURN_TIMEOUT - 1);

  localparam int LINES [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  state_e             state_q, state_d;
  logic [26:0]        board_q, board_d;
  logic               player_q, player_d;
  logic [3:0]         count_q, count_d;
  logic [1:0]         winner_q, winner_d;
  logic               tout_q, tout_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               acc_q, acc_d;
  logic               rej_q, rej_d;

  logic [2:0] sym;
  logic       legal;
  logic       won;

  assign sym = player_q ? SYM_X : SYM_O;

  always_comb begin
    legal = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (move_cell == 4'(k) && board_q[3*k +: 3] == EMPTY) begin
        legal = 1'b1;
      end
    end
  end

  // Only the player who just moved can have completed a line.
  always_comb begin
    won = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (board_q[3*LINES[l][0] +: 3] == sym &&
          board_q[3*LINES[l][1] +: 3] == sym &&
          board_q[3*LINES[l][2] +: 3] == sym) begin
        won = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    player_d = player_q;
    count_d  = count_q;
    winner_d = winner_q;
    tout_d   = tout_q;
    timer_d  = timer_q;
    acc_d    = 1'b0;
    rej_d    = 1'b0;
    if (start) begin
      state_d  = WAIT_MOVE;
      board_d  = BOARD_CLR;
      player_d = FIRST_PLAYER;
      count_d  = '0;
      winner_d = 2'b00;
      tout_d   = 1'b0;
      timer_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        WAIT_MOVE: begin
          timer_d = timer_q + 1'b1;
          if (move_valid && legal) begin
            for (int k = 0; k < 9; k++) begin
              if (move_cell == 4'(k)) begin
                board_d[3*k +: 3] = sym;
              end
            end
            count_d = count_q + 4'd1;
            acc_d   = 1'b1;
            state_d = CHECK;
          end else begin
            rej_d = move_valid;
            if (TURN_TIMEOUT != 0 && timer_q == TMAX) begin
              state_d  = DONE;
              winner_d = player_q ? 2'b01 : 2'b10;
              tout_d   = 1'b1;
            end
          end
        end
        CHECK: begin
          if (won) begin
            winner_d = player_q ? 2'b10 : 2'b01;
            state_d  = DONE;
          end else if (count_q == 4'd9) begin
            winner_d = 2'b11;
            state_d  = DONE;
          end else begin
            player_d = ~player_q;
            timer_d  = '0;
            state_d  = WAIT_MOVE;
          end
        end
        DONE: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      board_q  <= BOARD_CLR;
      player_q <= FIRST_PLAYER;
      count_q  <= '0;
      winner_q <= 2'b00;
      tout_q   <= 1'b0;
      timer_q  <= '0;
      acc_q    <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      player_q <= player_d;
      count_q  <= count_d;
      winner_q <= winner_d;
      tout_q   <= tout_d;
      timer_q  <= timer_d;
      acc_q    <= acc_d;
      rej_q    <= rej_d;
    end
  end

  assign move_ready     = (state_q == WAIT_MOVE);
  assign move_accept    = acc_q;
  assign move_reject    = rej_q;
  assign current_player = player_q;
  assign board          = board_q;
  assign move_count     = count_q;
  assign game_state     = state_q;
  assign winner         = winner_q;
  assign timeout        = tout_q;

endmodule

// File: doc/tic_tac_toe_game_ctrl.md
Name: tic_tac_toe_game_ctrl

Overview:
Sequential game controller for the tic-tac-toe datapath.
- Owns the 3x3 board register and alternates turns between player O and player X.
- Validates move requests, evaluates all 8 win lines after each accepted move, and declares win, draw or timeout forfeit.
- Sits between the player input logic and the display/win-status consumers.

Parameters:
FIRST_PLAYER, 1'b0, player who moves first after start (0 = O, 1 = X)
TURN_TIMEOUT, 0, cycles allowed per turn before forfeit; 0 disables the timeout
TIMER_W, 16, width of the turn timer; must satisfy TURN_TIMEOUT < 2^TIMER_W

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level-sampled; clears board and begins a new game
move_valid  input  1  a move request is present this cycle
move_cell  input  4  target cell, 0..8 row-major (0 = top_left, 8 = bottom_right)
move_ready  output  1  controller accepts move requests this cycle
move_accept  output  1  one-cycle pulse: previous-cycle move was written
move_reject  output  1  one-cycle pulse: previous-cycle move was illegal
current_player  output  1  player to move (0 = O, 1 = X)
board  output  27  nine 3-bit cells, cell k at [3k+2:3k]; 3'b000 = O, 3'b001 = X, 3'b011 = empty
move_count  output  4  accepted moves in the current game, 0..9
game_state  output  2  00 IDLE, 01 WAIT_MOVE, 10 CHECK, 11 DONE
winner  output  2  00 none, 01 O win, 10 X win, 11 draw
timeout  output  1  set in DONE when the game ended by forfeit

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: board all 3'b011, state IDLE, current_player = FIRST_PLAYER, move_count 0, winner 00, timeout 0, move_ready 0, move_accept/move_reject 0, timer 0.

Status outputs:
- move_ready = 1 only in WAIT_MOVE.
- Outputs are registered and change only on clock edges.

IDLE:
- start = 1 -> board cleared, current_player = FIRST_PLAYER, move_count 0, winner 00, timeout 0, timer 0; next state WAIT_MOVE.

WAIT_MOVE:
- Moves are sampled only when move_valid & move_ready.
- Legal move (move_cell <= 8 and the cell is 3'b011): write the cell with current_player's symbol (3'b000 or 3'b001), increment move_count, pulse move_accept on the next cycle; next state CHECK.
- Illegal move (move_cell 9..15, or cell occupied): board unchanged, pulse move_reject on the next cycle, stay in WAIT_MOVE; the timer keeps running.
- Timer increments each cycle in WAIT_MOVE.
- If TURN_TIMEOUT != 0 and the timer equals TURN_TIMEOUT-1 with no legal move this cycle: next state DONE, winner = opponent (01 if X timed out, 10 if O timed out), timeout = 1.

CHECK (always exactly 1 cycle):
- Evaluate 3 rows, 3 columns and 2 diagonals on the updated board. A line is won when all 3 cells equal the mover's symbol; empty cells never form a line.
- Line complete: winner = 01 (O) or 10 (X); next state DONE.
- Else if move_count == 9: winner = 11 (draw); next state DONE.
- Else toggle current_player, clear timer; next state WAIT_MOVE.

DONE:
- Board, winner and timeout hold; move_valid is ignored (no accept/reject pulses).
- start restarts the game exactly as from IDLE.

Latency:
- Legal move sampled at edge N: board updated at N; move_accept high during cycle N..N+1; winner valid after edge N+1.
- Minimum 2 cycles per turn.

Priority and boundaries:
- start in any state aborts the current game and restarts; start has priority over move_valid and timeout, so no pulses are generated that cycle.
- Legal move and timer expiry in the same cycle: the move wins and no forfeit occurs.
- start held high stays in WAIT_MOVE with a cleared board each cycle; moves are ignored while start = 1.
- rst_n asserted mid-game: immediate return to reset values regardless of state.
- The win line is checked only for the player who just moved.

Test Plan:
- Reset then start; O plays 0, X 3, O 1, X 4, O 2 -> 5 move_accept pulses, winner 01 one cycle after the 5th accept, game_state 11, move_count 5.
- Full draw sequence 0,1,2,4,3,5,7,6,8 -> winner 11 after the 9th accept, move_count 9, board has no empty cell.
- Move to an occupied cell, then move_cell = 12 -> two move_reject pulses, board and current_player unchanged, move_ready stays 1.
- TURN_TIMEOUT = 20, O idle for 20 cycles -> DONE, winner 10, timeout 1; a legal move on cycle 19 instead is accepted with no forfeit.
- start asserted with move_valid in the same cycle mid-game -> board all 3'b011, no pulses, move_count 0, current_player = FIRST_PLAYER.
- rst_n pulsed low while in CHECK -> outputs immediately at reset values; move_valid in DONE -> no pulses.
